// File: rtl/mem_access_ctrl.sv
`timescale 1ns/1ps
// Memory-stage controller: sequences data-memory loads/stores over req/ack,
// stalls the pipeline while an access is outstanding, aligns load data.
module mem_access_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] ALU,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall,
    output logic        MemtoReg,
    output logic [31:0] wb_data_mem,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic        wb_RegWrite,
    output logic        misaligned,
    output logic        bus_err
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic        rw_q;

    logic        is_mem;
    logic        is_load;
    logic        aligned;
    logic        start;
    logic        reject;
    logic        timeout_hit;
    logic        done_ack;
    logic        done_to;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [31:0] shifted;
    logic [31:0] load_val;

    assign is_mem  = MemRead | MemWrite;
    assign is_load = MemRead;

    // funct3[1:0]: 00 byte, 01 half, 1x word; the sign bit (funct3[2]) does not matter here
    always_comb begin
        aligned = 1'b1;
        if (funct3[1])
            aligned = (ALU[1:0] == 2'b00);
        else if (funct3[0])
            aligned = ~ALU[0];
    end

    assign start       = (state == IDLE) & ex_valid & is_mem & aligned;
    assign reject      = (state == IDLE) & ex_valid & is_mem & ~aligned;
    assign timeout_hit = (state == BUSY) && (cnt == 8'(TIMEOUT - 1));
    assign done_ack    = (state == BUSY) & dmem_ack;
    assign done_to     = (state == BUSY) & ~dmem_ack & timeout_hit;

    always_comb begin
        be_new    = 4'b1111;
        wdata_new = rs2_data;
        if (!is_load) begin
            if (funct3[1]) begin
                be_new    = 4'b1111;
                wdata_new = rs2_data;
            end else if (funct3[0]) begin
                be_new    = 4'b0011 << ALU[1:0];
                wdata_new = {2{rs2_data[15:0]}};
            end else begin
                be_new    = 4'b0001 << ALU[1:0];
                wdata_new = {4{rs2_data[7:0]}};
            end
        end
    end

    assign shifted = dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_val = {24'b0, shifted[7:0]};
            3'b101:  load_val = {16'b0, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // Stall holds the MEM-stage instruction until the completing cycle (ack or timeout)
    assign stall = ~rst & (start | ((state == BUSY) & ~dmem_ack & ~timeout_hit));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (done_ack || done_to) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 8'd0;
            f3_q        <= 3'd0;
            off_q       <= 2'd0;
            rd_q        <= 5'd0;
            rw_q        <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= 32'd0;
            dmem_wdata  <= 32'd0;
            dmem_be     <= 4'd0;
            MemtoReg    <= 1'b0;
            wb_data_mem <= 32'd0;
            wb_valid    <= 1'b0;
            wb_rd       <= 5'd0;
            wb_RegWrite <= 1'b0;
            misaligned  <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            state       <= state_nxt;
            wb_valid    <= 1'b0;
            MemtoReg    <= 1'b0;
            wb_RegWrite <= 1'b0;
            misaligned  <= 1'b0;
            bus_err     <= 1'b0;

            if (start) begin
                cnt        <= 8'd0;
                f3_q       <= funct3;
                off_q      <= ALU[1:0];
                rd_q       <= rd;
                rw_q       <= RegWrite;
                dmem_req   <= 1'b1;
                dmem_we    <= ~is_load;
                dmem_addr  <= {ALU[31:2], 2'b00};
                dmem_wdata <= wdata_new;
                dmem_be    <= be_new;
            end else if (reject) begin
                misaligned <= 1'b1;
                wb_valid   <= 1'b1;
                wb_rd      <= rd;
            end else if ((state == IDLE) && ex_valid) begin
                wb_valid    <= 1'b1;
                wb_rd       <= rd;
                wb_RegWrite <= RegWrite;
            end

            if (state == BUSY) begin
                cnt <= cnt + 8'd1;
                if (done_ack) begin
                    dmem_req    <= 1'b0;
                    wb_valid    <= 1'b1;
                    wb_rd       <= rd_q;
                    MemtoReg    <= ~dmem_we;
                    wb_RegWrite <= ~dmem_we & rw_q;
                    if (!dmem_we) wb_data_mem <= load_val;
                end else if (done_to) begin
                    dmem_req <= 1'b0;
                    wb_valid <= 1'b1;
                    wb_rd    <= rd_q;
                    bus_err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
`timescale 1ns/1ps
// Bench for mem_access_ctrl: directed plan steps plus random accesses,
// checked against a size/offset reference model of RISC-V load/store rules.
module tb_mem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, MemRead, MemWrite, RegWrite;
    logic [2:0]  funct3;
    logic [31:0] ALU, rs2_data;
    logic [4:0]  rd;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;
    logic        stall, MemtoReg;
    logic [31:0] wb_data_mem;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_RegWrite, misaligned, bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_ctrl #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .MemRead(MemRead),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .funct3(funct3), .ALU(ALU),
        .rs2_data(rs2_data), .rd(rd), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
        .MemtoReg(MemtoReg), .wb_data_mem(wb_data_mem), .wb_valid(wb_valid),
        .wb_rd(wb_rd), .wb_RegWrite(wb_RegWrite), .misaligned(misaligned),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: access size in bytes from funct3
    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic ref_aligned(input logic [2:0] f3, input logic [31:0] a);
        return (a % acc_size(f3)) == 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic ld, input logic [2:0] f3, input logic [31:0] a);
        int sz;
        int off;
        logic [3:0] be;
        if (ld) return 4'b1111;
        sz  = acc_size(f3);
        off = a % 4;
        be  = 4'b0000;
        for (int b = 0; b < 4; b++)
            if (b >= off && b < off + sz) be[b] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] v);
        logic [31:0] w;
        int sz;
        sz = acc_size(f3);
        for (int b = 0; b < 4; b++)
            w[8*b +: 8] = v[8*(b % sz) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rdata);
        logic [31:0] t;
        logic [7:0]  b8;
        logic [15:0] h16;
        t   = rdata >> (8 * (a % 4));
        b8  = t[7:0];
        h16 = t[15:0];
        case (f3)
            3'b000:  return 32'($signed(b8));
            3'b001:  return 32'($signed(h16));
            3'b100:  return 32'(b8);
            3'b101:  return 32'(h16);
            default: return t;
        endcase
    endfunction

    // One instruction through the MEM stage; ack_at = BUSY cycle of the ack, 0 = none
    task automatic do_access(input logic mr, input logic mw, input logic rw,
                             input logic [2:0] f3, input logic [31:0] alu,
                             input logic [31:0] rs2, input logic [4:0] rdn,
                             input int ack_at, input logic [31:0] rdata);
        logic mem, ld, al, acked, done;
        int   i;
        mem = mr | mw;
        ld  = mr;
        al  = ref_aligned(f3, alu);
        @(negedge clk);
        ex_valid = 1'b1; MemRead = mr; MemWrite = mw; RegWrite = rw;
        funct3 = f3; ALU = alu; rs2_data = rs2; rd = rdn; dmem_ack = 1'b0;
        #1;
        check("idle_stall", 32'(stall), 32'(mem && al));
        check("idle_req", 32'(dmem_req), 32'd0);
        if (!mem) begin
            @(negedge clk); ex_valid = 1'b0; #1;
            check("alu_wb_valid", 32'(wb_valid), 32'd1);
            check("alu_memtoreg", 32'(MemtoReg), 32'd0);
            check("alu_wb_rd", 32'(wb_rd), 32'(rdn));
            check("alu_wb_regwrite", 32'(wb_RegWrite), 32'(rw));
        end else if (!al) begin
            @(negedge clk); ex_valid = 1'b0; #1;
            check("mis_flag", 32'(misaligned), 32'd1);
            check("mis_wb_valid", 32'(wb_valid), 32'd1);
            check("mis_wb_regwrite", 32'(wb_RegWrite), 32'd0);
            check("mis_req", 32'(dmem_req), 32'd0);
            check("mis_stall", 32'(stall), 32'd0);
        end else begin
            i = 0;
            done = 1'b0;
            while (!done) begin
                i++;
                @(negedge clk);
                dmem_ack   = (i == ack_at);
                dmem_rdata = (i == ack_at) ? rdata : $urandom;
                #1;
                check("busy_req", 32'(dmem_req), 32'd1);
                check("busy_addr", dmem_addr, alu & 32'hFFFF_FFFC);
                check("busy_we", 32'(dmem_we), 32'(!ld));
                check("busy_be", 32'(dmem_be), 32'(ref_be(ld, f3, alu)));
                if (!ld) check("busy_wdata", dmem_wdata, ref_wdata(f3, rs2));
                check("busy_wb_valid", 32'(wb_valid), 32'd0);
                check("busy_stall", 32'(stall), 32'(!((i == ack_at) || (i == TO))));
                done = (i == ack_at) || (i == TO);
            end
            acked = (i == ack_at);
            @(negedge clk); ex_valid = 1'b0; dmem_ack = 1'b0; #1;
            check("done_wb_valid", 32'(wb_valid), 32'd1);
            check("done_bus_err", 32'(bus_err), 32'(!acked));
            check("done_memtoreg", 32'(MemtoReg), 32'(acked && ld));
            check("done_wb_regwrite", 32'(wb_RegWrite), 32'(acked && ld && rw));
            check("done_req", 32'(dmem_req), 32'd0);
            if (acked && ld) begin
                check("done_wb_rd", 32'(wb_rd), 32'(rdn));
                check("done_load_data", wb_data_mem, ref_load(f3, alu, rdata));
            end
        end
        @(negedge clk); #1;
        check("pulse_wb_valid", 32'(wb_valid), 32'd0);
        check("pulse_misaligned", 32'(misaligned), 32'd0);
        check("pulse_bus_err", 32'(bus_err), 32'd0);
    endtask

    initial begin
        logic [2:0] ld_f3 [5];
        int         op;
        logic [2:0] f3;
        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

        // Reset with a load presented: stall must stay low
        rst = 1'b1; ex_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; RegWrite = 1'b1;
        funct3 = 3'b010; ALU = 32'h100; rs2_data = 32'd0; rd = 5'd1;
        dmem_ack = 1'b0; dmem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_we", 32'(dmem_we), 32'd0);
        check("rst_addr", dmem_addr, 32'd0);
        check("rst_wdata", dmem_wdata, 32'd0);
        check("rst_be", 32'(dmem_be), 32'd0);
        check("rst_memtoreg", 32'(MemtoReg), 32'd0);
        check("rst_wb_data", wb_data_mem, 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_rd", 32'(wb_rd), 32'd0);
        check("rst_wb_regwrite", 32'(wb_RegWrite), 32'd0);
        check("rst_misaligned", 32'(misaligned), 32'd0);
        check("rst_bus_err", 32'(bus_err), 32'd0);
        rst = 1'b0; ex_valid = 1'b0;

        // Directed plan steps
        do_access(1'b0, 1'b0, 1'b1, 3'b000, 32'h0, 32'h0, 5'd5, 0, 32'h0);
        do_access(1'b1, 1'b0, 1'b1, 3'b000, 32'h1003, 32'h0, 5'd7, 2, 32'h80FF_FFFF);
        check("lb_value", wb_data_mem, 32'hFFFF_FF80);
        do_access(1'b1, 1'b0, 1'b1, 3'b100, 32'h1003, 32'h0, 5'd8, 2, 32'h80FF_FFFF);
        check("lbu_value", wb_data_mem, 32'h0000_0080);
        do_access(1'b0, 1'b1, 1'b1, 3'b001, 32'h2002, 32'h1234_ABCD, 5'd9, 1, 32'h0);
        do_access(1'b1, 1'b0, 1'b1, 3'b010, 32'h0006, 32'h0, 5'd3, 1, 32'h0);
        do_access(1'b1, 1'b0, 1'b1, 3'b010, 32'h0040, 32'h0, 5'd4, 0, 32'h0);
        do_access(1'b1, 1'b0, 1'b1, 3'b010, 32'h0044, 32'h0, 5'd4, TO, 32'hDEAD_BEEF);
        do_access(1'b1, 1'b1, 1'b1, 3'b001, 32'h0046, 32'h0, 5'd6, 1, 32'h8001_7FFF);

        // Ack while idle is ignored
        @(negedge clk); dmem_ack = 1'b1; ex_valid = 1'b0;
        @(negedge clk); dmem_ack = 1'b0; #1;
        check("idle_ack_wb_valid", 32'(wb_valid), 32'd0);
        check("idle_ack_req", 32'(dmem_req), 32'd0);

        // Reset in BUSY cycle 2 abandons the access
        @(negedge clk);
        ex_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; RegWrite = 1'b1;
        funct3 = 3'b010; ALU = 32'h300; rd = 5'd11;
        @(negedge clk); #1;
        check("rstb_req1", 32'(dmem_req), 32'd1);
        @(negedge clk); rst = 1'b1; #1;
        check("rstb_stall", 32'(stall), 32'd0);
        @(negedge clk); rst = 1'b0; ex_valid = 1'b0; #1;
        check("rstb_req_drop", 32'(dmem_req), 32'd0);
        check("rstb_wb_valid", 32'(wb_valid), 32'd0);
        @(negedge clk); #1;
        check("rstb_wb_valid2", 32'(wb_valid), 32'd0);
        do_access(1'b1, 1'b0, 1'b1, 3'b010, 32'h300, 32'h0, 5'd11, 1, 32'h1357_9BDF);

        // Random accesses
        for (int n = 0; n < 60; n++) begin
            op = $urandom_range(0, 3);
            if (op == 2) f3 = 3'($urandom_range(0, 2));
            else         f3 = ld_f3[$urandom_range(0, 4)];
            do_access(op == 1 || op == 3, op == 2 || op == 3, 1'($urandom_range(0, 1)),
                      f3, $urandom, $urandom, 5'($urandom_range(0, 31)),
                      $urandom_range(0, TO + 1), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-stage controller for the RISC-V core. It sequences data-memory loads and stores over a req/ack handshake and stalls the pipeline while an access is outstanding. It aligns and extends load data, generates byte enables for stores, and drives the `MemtoReg` select consumed by the write-back mux (ALU result vs. memory data). It sits between the EX/MEM pipeline register and the write-back stage.

## Interface
Parameters:
- `TIMEOUT`, default 15: maximum cycles spent in BUSY without `dmem_ack` before the access is aborted. Range 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `ex_valid`  in  1  a valid instruction is present in the MEM stage.
- `MemRead`  in  1  the instruction is a load.
- `MemWrite`  in  1  the instruction is a store.
- `RegWrite`  in  1  the instruction writes `rd`.
- `funct3`  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `ALU`  in  32  ALU result; used as the effective address for memory operations.
- `rs2_data`  in  32  store data.
- `rd`  in  5  destination register.
- `dmem_req`  out  1  memory request.
- `dmem_we`  out  1  1 = write.
- `dmem_addr`  out  32  word-aligned address, `{ALU[31:2],2'b00}`.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_be`  out  4  byte enables.
- `dmem_ack`  in  1  memory completion.
- `dmem_rdata`  in  32  read data; valid in the cycle `dmem_ack`=1.
- `stall`  out  1  hold the PC and the IF/ID/EX/MEM registers (combinational).
- `MemtoReg`  out  1  write-back mux select: 1 = `wb_data_mem`, 0 = ALU.
- `wb_data_mem`  out  32  aligned, extended load data.
- `wb_valid`  out  1  one-cycle pulse; write-back outputs are valid.
- `wb_rd`  out  5  destination register for write-back.
- `wb_RegWrite`  out  1  register-file write enable.
- `misaligned`  out  1  one-cycle pulse; misaligned access rejected.
- `bus_err`  out  1  one-cycle pulse; access timed out.

## Operation
- The FSM has two states, IDLE and BUSY.
- Start condition: `start` = IDLE & `ex_valid` & (`MemRead` | `MemWrite`) & aligned.
  - If both `MemRead` and `MemWrite` are high, the instruction is treated as a load.
- Alignment rules:
  - H/HU/SH require `ALU[0]`=0.
  - W/SW require `ALU[1:0]`=0.
  - Bytes are always aligned.
- IDLE, non-memory instruction (`ex_valid` with neither `MemRead` nor `MemWrite`):
  - Next cycle: `wb_valid`=1, `MemtoReg`=0, `wb_RegWrite`=`RegWrite`, `wb_rd`=`rd`.
  - No stall.
- IDLE, misaligned access:
  - No memory request is issued.
  - Next cycle: `misaligned`=1, `wb_valid`=1, `wb_RegWrite`=0.
  - No stall.
- IDLE, `start`:
  - `stall`=1 in the same cycle.
  - Latch address, `we`, `be`, `wdata`, `funct3`, `rd`, and `RegWrite`; move to BUSY.
  - Clear the timeout counter.
- BUSY:
  - `dmem_req`=1; address, `we`, `be`, and `wdata` are held stable.
  - The counter increments each cycle.
- BUSY & `dmem_ack`:
  - `stall`=0 in that cycle.
  - At the edge: go to IDLE and capture `dmem_rdata`.
  - Next cycle `wb_valid`=1:
    - Load: `MemtoReg`=1, `wb_RegWrite`=latched `RegWrite`.
    - Store: `MemtoReg`=0, `wb_RegWrite`=0.
- BUSY & counter = `TIMEOUT`-1 & !`dmem_ack`:
  - `stall`=0 in that cycle.
  - At the edge: go to IDLE and drop `dmem_req`.
  - Next cycle: `bus_err`=1, `wb_valid`=1, `wb_RegWrite`=0.
  - If ack and timeout coincide, ack wins.
- Store lanes:
  - SB: `be`=0001<<`ALU[1:0]`, `wdata`={4{`rs2_data[7:0]`}}.
  - SH: `be`=0011<<`ALU[1:0]`, `wdata`={2{`rs2_data[15:0]`}}.
  - SW: `be`=1111, `wdata`=`rs2_data`.
  - Loads: `be`=1111, `we`=0.
- Load extraction:
  - Shift `dmem_rdata` right by 8·`ALU[1:0]`.
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- Pipeline hand-off:
  - The MEM-stage instruction is held while `stall`=1.
  - After the completing edge the pipeline advances, so the next IDLE cycle carries the next instruction.
  - A held instruction is never restarted.

## Timing
- Reset: at a rising edge with `rst`=1, the state goes to IDLE and the counter clears.
  - All registered outputs (`dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_be`, `MemtoReg`, `wb_data_mem`, `wb_valid`, `wb_rd`, `wb_RegWrite`, `misaligned`, `bus_err`) become 0.
  - `stall`=0 while `rst`=1.
- Reset during BUSY abandons the access: `dmem_req`=0 from the next cycle and no write-back pulse is produced. The memory must tolerate a dropped request.
- Latencies:
  - Non-memory instruction: 1 cycle to `wb_valid`.
  - Memory access: `dmem_req` rises 1 cycle after `start`; `wb_valid` follows 1 cycle after the ack cycle.
  - Minimum load/store: 3 cycles total, with ack in the first BUSY cycle.
- `dmem_ack` is sampled only in BUSY; an ack seen in IDLE is ignored.
- `wb_valid`, `misaligned`, and `bus_err` are exactly one cycle wide.

## Test plan
- Non-memory instruction: `ex_valid`=1, `RegWrite`=1, `rd`=5 → next cycle `wb_valid`=1, `MemtoReg`=0, `wb_rd`=5, `stall` never asserted.
- LB at `ALU`=0x1003, `dmem_rdata`=0x80FF_FFFF, ack in BUSY cycle 2:
  - `dmem_addr`=0x1000, `be`=1111, `stall` high for 2 cycles.
  - Then `wb_data_mem`=0xFFFF_FF80, `MemtoReg`=1.
  - Repeat with LBU → `wb_data_mem`=0x0000_0080.
- SH at `ALU`=0x2002, `rs2_data`=0x1234_ABCD:
  - `dmem_we`=1, `be`=1100, `wdata`=0xABCD_ABCD.
  - `wb_RegWrite`=0 after ack.
- LW at `ALU`=0x0006 → no `dmem_req`, `misaligned`=1, `wb_valid`=1, `wb_RegWrite`=0, `stall`=0.
- `TIMEOUT`=4, ack never arrives:
  - `dmem_req` high for exactly 4 cycles.
  - Then `bus_err`=1 and `wb_valid`=1; `stall` low in BUSY cycle 4.
  - Ack arriving in that same cycle → normal completion instead.
- `rst`=1 in BUSY cycle 2 → `dmem_req`=0 the following cycle, no `wb_valid`; the next load after reset completes normally.
